// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer:
// register offsets, CTRL bit layout, mode and FSM state encodings.
package timer_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Only 01 reloads; the reserved encodings 10/11 fall back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt; programmed through a 4-word register window.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic [31:0]       preset_reg, preset_next;
  logic [31:0]       count_reg, count_next;
  logic [1:0]        state_reg, state_next;
  logic              irq_flag_reg, irq_flag_next;

  logic       en;
  logic [1:0] mode;

  assign en   = ctrl_reg[CTRL_EN];
  assign mode = ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO];

  always_comb begin
    ctrl_next     = ctrl_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    state_next    = state_reg;
    irq_flag_next = irq_flag_reg;

    case (state_reg)
      ST_IDLE: begin
        if (en) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        count_next = preset_reg;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (count_reg > 32'd1) begin
          count_next = count_reg - 32'd1;
        end else begin
          count_next    = 32'd0;
          irq_flag_next = 1'b1;
          state_next    = ST_INT;
        end
      end
      default: begin
        if (is_reload(mode)) begin
          irq_flag_next = 1'b0;
          state_next    = ST_LOAD;
        end else begin
          ctrl_next[CTRL_EN] = 1'b0;
          state_next         = ST_IDLE;
        end
      end
    endcase

    // CPU writes are applied last so they override the FSM's own En clear
    // and acknowledge any pending interrupt on the same edge.
    if (WE) begin
      case (Addr)
        REG_CTRL: begin
          ctrl_next     = Din[CTRL_W-1:0];
          irq_flag_next = 1'b0;
        end
        REG_PRESET: preset_next = Din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg     <= '0;
      preset_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= ST_IDLE;
      irq_flag_reg <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      state_reg    <= state_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  always_comb begin
    case (Addr)
      REG_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_reg};
      REG_PRESET: Dout = preset_reg;
      REG_COUNT:  Dout = count_reg;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl_reg[CTRL_IM] & irq_flag_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with fixed
// expectations plus randomized register traffic against a reference model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model. "phase" tracks where the timer is in its programme:
  // waiting for En, about to reload, counting, or just expired.
  bit [3:0]  m_ctrl;
  bit [31:0] m_preset;
  bit [31:0] m_count;
  bit        m_flag;
  string     m_phase = "idle";

  task automatic model_edge(input bit r, input bit we, input bit [1:0] a, input bit [31:0] d);
    bit [3:0]  c  = m_ctrl;
    bit [31:0] p  = m_preset;
    bit [31:0] n  = m_count;
    bit        f  = m_flag;
    string     ph = m_phase;
    if (r) begin
      m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = "idle";
      return;
    end
    if (m_phase == "idle") begin
      if (m_ctrl[0]) ph = "load";
    end else if (m_phase == "load") begin
      n = m_preset; ph = "count";
    end else if (m_phase == "count") begin
      if (!m_ctrl[0]) ph = "idle";
      else if (m_count >= 2) n = m_count - 1;
      else begin n = 0; f = 1; ph = "expired"; end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin f = 0; ph = "load"; end
      else begin c[0] = 0; ph = "idle"; end
    end
    if (we && a == 0) begin c = d[3:0]; f = 0; end
    if (we && a == 1) p = d;
    m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_phase = ph;
  endtask

  logic [31:0] rd [4];
  int          cyc = 0;

  // One clock: apply inputs, advance model, then compare IRQ and all four reads.
  task automatic cycle(input bit r, input bit we, input bit [1:0] a, input bit [31:0] d);
    bit [31:0] exp_rd;
    reset = r; WE = we; Addr = a; Din = d;
    @(posedge clk);
    model_edge(r, we, a, d);
    cyc++;
    #1;
    reset = 1'b0; WE = 1'b0;
    check("irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
    for (int i = 0; i < 4; i++) begin
      Addr = 2'(i);
      #1;
      rd[i] = Dout;
      case (i)
        0: exp_rd = {28'd0, m_ctrl};
        1: exp_rd = m_preset;
        2: exp_rd = m_count;
        default: exp_rd = 32'd0;
      endcase
      check($sformatf("rd%0d", i), rd[i], exp_rd);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; WE = 1'b0; Addr = 2'd0; Din = 32'd0;

    // Reset values
    cycle(1, 0, 0, 0);
    check("rst_ctrl", rd[0], 32'd0);
    check("rst_preset", rd[1], 32'd0);
    check("rst_count", rd[2], 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);

    // One-shot, P=5: IRQ from edge E0+7 onward, En self-clears
    cycle(0, 1, 1, 5);
    cycle(0, 1, 0, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("os_irq_k%0d", k), {31'd0, IRQ}, {31'd0, k >= 7});
    end
    check("os_ctrl", rd[0], 32'h8);
    cycle(0, 1, 0, 32'h8);
    check("os_ack", {31'd0, IRQ}, 32'd0);

    // Auto-reload, P=3: pulse every 5 cycles, COUNT 3,2,1,0
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 3);
    cycle(0, 1, 0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("ar_irq_k%0d", k), {31'd0, IRQ}, {31'd0, (k >= 5) && ((k - 5) % 5 == 0)});
      if (k >= 2 && k <= 5) check($sformatf("ar_cnt_k%0d", k), rd[2], 32'(5 - k));
    end

    // PRESET 0 and 1 both expire at E0+3
    for (int p = 0; p <= 1; p++) begin
      cycle(1, 0, 0, 0);
      cycle(0, 1, 1, 32'(p));
      cycle(0, 1, 0, 32'h9);
      for (int k = 1; k <= 4; k++) begin
        cycle(0, 0, 0, 0);
        check($sformatf("p%0d_irq_k%0d", p, k), {31'd0, IRQ}, {31'd0, k >= 3});
      end
    end

    // Disable mid-count: COUNT freezes at 7, no IRQ
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 10);
    cycle(0, 1, 0, 32'h9);
    idle_n(4);
    cycle(0, 1, 0, 32'h8);
    idle_n(12);
    check("frz_count", rd[2], 32'd7);
    check("frz_irq", {31'd0, IRQ}, 32'd0);

    // Masked expiry, then 0x9 restarts; COUNT and addr 3 ignore writes
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 2);
    cycle(0, 1, 0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("msk_irq_k%0d", k), {31'd0, IRQ}, 32'd0);
    end
    cycle(0, 1, 2, 32'hDEAD_BEEF);
    check("ro_count", rd[2], 32'd0);
    cycle(0, 1, 3, 32'h1234_5678);
    check("ro_addr3", rd[3], 32'd0);
    check("ro_ctrl", rd[0], 32'h0);
    cycle(0, 1, 0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("rs_irq_k%0d", k), {31'd0, IRQ}, {31'd0, k >= 4});
    end

    // Reset while counting with COUNT = 2
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 5);
    cycle(0, 1, 0, 32'h9);
    idle_n(5);
    check("mid_count", rd[2], 32'd2);
    cycle(1, 0, 0, 0);
    check("mid_ctrl", rd[0], 32'd0);
    check("mid_preset", rd[1], 32'd0);
    check("mid_cnt0", rd[2], 32'd0);
    check("mid_irq", {31'd0, IRQ}, 32'd0);

    // Randomized register traffic against the model
    for (int i = 0; i < 2000; i++) begin
      int sel;
      bit [31:0] d;
      sel = int'($urandom_range(0, 99));
      if (sel == 0) begin
        cycle(1, 0, 0, 0);
      end else if (sel < 10) begin
        d = $urandom;
        d[3] = ($urandom_range(0, 3) != 0);
        d[0] = ($urandom_range(0, 3) != 0);
        cycle(0, 1, 0, d);
      end else if (sel < 16) begin
        d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
        cycle(0, 1, 1, d);
      end else if (sel < 19) begin
        cycle(0, 1, 2'($urandom_range(2, 3)), $urandom);
      end else begin
        cycle(0, 0, 2'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
